cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Two-master arbiter that shares the CPU's external bus (address, write data, write enable, read data, data-ready) between the CPU core (master 0) and a DMA/peripheral engine (master 1). It sits between the masters and the bus fabric, runs one transaction at a time with fair round-robin selection, and holds the winner's request latched until the slave answers. A cycle-count watchdog terminates the transaction with an error if the slave never answers.

## Interface
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 255, cycles in ACCESS before a forced error completion; 0 disables the watchdog. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- i_cpu_clk  in  1  sole clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_m0_req, i_m1_req  in  1 each  level request; held high until that master's done pulse.
- i_m0_we, i_m1_we  in  1 each  1 = write, 0 = read.
- i_m0_addr, i_m1_addr  in  ADDR_W each  transaction address.
- i_m0_wdata, i_m1_wdata  in  DATA_W each  write data.
- o_m0_rdata, o_m1_rdata  out  DATA_W each  read data. Registered; holds until the next read completion for that master.
- o_m0_done, o_m1_done  out  1 each  one-cycle completion pulse.
- o_m0_err, o_m1_err  out  1 each  valid with done; 1 = watchdog timeout.
- o_grant  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = none.
- o_bus_cyc  out  1  transaction in progress.
- o_bus_we  out  1  latched write enable.
- o_bus_addr  out  ADDR_W  latched address.
- o_bus_data  out  DATA_W  latched write data.
- i_bus_data  in  DATA_W  slave read data.
- i_bus_data_ready  in  1  slave completion strobe; one cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Sample both requests.
  - Exactly one request high: grant it.
  - Both high: grant the master that was not last granted.
  - On grant: latch we/addr/wdata into o_bus_*, set o_grant and o_bus_cyc, clear the watchdog, go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS**
  - o_bus_cyc=1; o_bus_* stay stable even if master inputs change.
  - On i_bus_data_ready=1:
    - If a read, latch i_bus_data into the winner's rdata. Writes leave rdata unchanged.
    - Go to DONE with err=0.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0):
    - Go to DONE with err=1.
    - If a read, load the winner's rdata with all ones.
  - If ready and timeout occur in the same cycle, ready wins (err=0).
- **DONE**
  - o_bus_cyc=0 and o_grant=00.
  - Winner's done=1 for this cycle; its err is valid this cycle only.
  - Update last_grant to the winner.
  - Go to IDLE.
- i_bus_data_ready outside ACCESS is ignored.
- Masters must drop req in the cycle after done is seen. A req still high in IDLE is treated as a new transaction.
- Reset state:
  - FSM in IDLE; last_grant = m1, so m0 wins the first contention.
  - o_grant=00; o_bus_cyc, o_bus_we, o_bus_addr, o_bus_data = 0.
  - done/err = 0; rdata = 0; watchdog = 0.
- Reset mid-transaction: abort at the next edge; no done pulse; outputs go to their reset values.

## Timing
- Request seen in IDLE at edge N: o_bus_cyc=1 in cycle N+1.
- Ready in cycle R: done=1 in cycle R+1, and rdata is valid from R+1 on.
- Back-to-back: the next grant is issued at the earliest 1 cycle after DONE. Minimum transaction period is 3 cycles with zero-wait slaves (ready in the first ACCESS cycle).
- Timeout: the Nth ACCESS cycle without ready (N=TIMEOUT_CYCLES) leads to DONE in the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold i_rst 2 cycles while m0 requests → o_bus_cyc=0, o_grant=00, all outputs 0, no done. Release → grant m0 1 cycle later.
- **Single read:**
  - m0 reads addr 0x0000_1234; slave drives ready 2 cycles into ACCESS with data 0xDEAD_BEEF.
  - Required: o_m0_rdata=0xDEAD_BEEF, o_m0_done one cycle, err=0, o_m1_rdata unchanged.
- **Contention, round-robin:** both request continuously, zero-wait slave → grants alternate m0, m1, m0, m1. Each done pulses exactly once per grant.
- **Write stability:**
  - m1 writes 0x55AA to addr 0x10; m1 changes addr/data during ACCESS.
  - Required: o_bus_addr=0x10, o_bus_data=0x55AA, o_bus_we=1 throughout; rdata unchanged after done.
- **Timeout:**
  - TIMEOUT_CYCLES=4; m0 reads; slave never answers.
  - Required: done and err=1 in the cycle after the 4th ACCESS cycle; o_m0_rdata=0xFFFF_FFFF.
  - Repeat with ready on the 4th cycle → err=0 with the slave's data.
- **Abort and stray ready:**
  - Assert i_rst during ACCESS → no done pulse, IDLE next cycle.
  - A ready pulse while in IDLE → ignored; no done, no rdata change.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one external CPU bus between the CPU core (m0)
// and a DMA/peripheral engine (m1). One transaction at a time, round-robin
// on contention, request latched until the slave answers or the watchdog
// forces an error completion. Every output is driven straight from a flop.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | no owner; arbitrate requests and latch the winner's request
//  ACCESS | bus cycle open; wait for slave ready or watchdog expiry
//  DONE   | bus released; winner's done (and err) pulse for one cycle

module cpu_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_cpu_clk,
  input  logic              i_rst,

  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_done,
  output logic              o_m0_err,

  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_done,
  output logic              o_m1_err,

  output logic [1:0]        o_grant,
  output logic              o_bus_cyc,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_data_ready
);

  // Watchdog counts completed ACCESS cycles; expiry is detected one count
  // early (wd == TIMEOUT-1) so the counter never needs to hold TIMEOUT+1.
  localparam int unsigned WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned WD_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);
  localparam logic            WD_ON   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WD_W-1:0] wd;
  logic            owner_m1;   // winner of the current/last transaction
  logic            last_m1;    // round-robin history: 1 = m1 was last granted

  logic pick_m0;
  logic pick_m1;
  logic start;
  logic in_access;
  logic ready_hit;
  logic timeout_hit;
  logic to_hit;
  logic finish;

  logic [1:0]        grant_d;
  logic              cyc_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] rdata0_d;
  logic [DATA_W-1:0] rdata1_d;
  logic              done0_d;
  logic              done1_d;
  logic              err0_d;
  logic              err1_d;
  logic [WD_W-1:0]   wd_d;
  logic              owner_d;
  logic              last_d;

  // Arbitration: a lone requester wins; on contention the one not last granted wins.
  assign pick_m0 = (state == S_IDLE) && i_m0_req && (!i_m1_req || last_m1);
  assign pick_m1 = (state == S_IDLE) && i_m1_req && (!i_m0_req || !last_m1);
  assign start   = pick_m0 || pick_m1;

  // Completion: slave ready takes priority over a watchdog expiry in the same cycle.
  assign in_access   = (state == S_ACCESS);
  assign ready_hit   = in_access && i_bus_data_ready;
  assign timeout_hit = WD_ON && (wd == WD_LAST);
  assign to_hit      = in_access && !i_bus_data_ready && timeout_hit;
  assign finish      = ready_hit || to_hit;

  // State register.
  always_ff @(posedge i_cpu_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)  state_nxt = S_ACCESS;
      S_ACCESS: if (finish) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and bookkeeping.
  always_comb begin
    grant_d  = o_grant;
    cyc_d    = o_bus_cyc;
    we_d     = o_bus_we;
    addr_d   = o_bus_addr;
    data_d   = o_bus_data;
    rdata0_d = o_m0_rdata;
    rdata1_d = o_m1_rdata;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    wd_d     = wd;
    owner_d  = owner_m1;
    last_d   = last_m1;

    if (start) begin
      grant_d = {pick_m1, pick_m0};
      cyc_d   = 1'b1;
      we_d    = pick_m1 ? i_m1_we    : i_m0_we;
      addr_d  = pick_m1 ? i_m1_addr  : i_m0_addr;
      data_d  = pick_m1 ? i_m1_wdata : i_m0_wdata;
      owner_d = pick_m1;
      wd_d    = '0;
    end

    if (in_access && !finish) begin
      wd_d = wd + WD_W'(1);
    end

    if (finish) begin
      grant_d = 2'b00;
      cyc_d   = 1'b0;
      done0_d = !owner_m1;
      done1_d = owner_m1;
      err0_d  = to_hit && !owner_m1;
      err1_d  = to_hit && owner_m1;
      // Reads return slave data, or all ones when the watchdog gave up.
      if (!o_bus_we) begin
        if (owner_m1) begin
          rdata1_d = ready_hit ? i_bus_data : {DATA_W{1'b1}};
        end else begin
          rdata0_d = ready_hit ? i_bus_data : {DATA_W{1'b1}};
        end
      end
    end

    if (state == S_DONE) begin
      last_d = owner_m1;
    end
  end

  // Output and bookkeeping registers; reset aborts any open transaction silently.
  always_ff @(posedge i_cpu_clk) begin
    if (i_rst) begin
      o_grant    <= 2'b00;
      o_bus_cyc  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
      o_m0_rdata <= '0;
      o_m1_rdata <= '0;
      o_m0_done  <= 1'b0;
      o_m1_done  <= 1'b0;
      o_m0_err   <= 1'b0;
      o_m1_err   <= 1'b0;
      wd         <= '0;
      owner_m1   <= 1'b0;
      last_m1    <= 1'b1;
    end else begin
      o_grant    <= grant_d;
      o_bus_cyc  <= cyc_d;
      o_bus_we   <= we_d;
      o_bus_addr <= addr_d;
      o_bus_data <= data_d;
      o_m0_rdata <= rdata0_d;
      o_m1_rdata <= rdata1_d;
      o_m0_done  <= done0_d;
      o_m1_done  <= done1_d;
      o_m0_err   <= err0_d;
      o_m1_err   <= err1_d;
      wd         <= wd_d;
      owner_m1   <= owner_d;
      last_m1    <= last_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a transaction model.

module tb_cpu_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [1:0]  grant;
  logic        bus_cyc, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ready;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_cpu_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_rdata(m0_rdata), .o_m0_done(m0_done), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_rdata(m1_rdata), .o_m1_done(m1_done), .o_m1_err(m1_err),
    .o_grant(grant), .o_bus_cyc(bus_cyc), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_data(bus_wdata),
    .i_bus_data(bus_rdata), .i_bus_data_ready(bus_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // open: a transaction holds the bus; age: ACCESS cycles already spent.
  bit          open, in_done;
  int          age, owner, last;
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] e_rdata [2];
  logic [1:0]  e_done, e_err;

  task automatic model_reset();
    open = 0; in_done = 0; age = 0; owner = 0; last = 1;
    t_we = 0; t_addr = 0; t_wdata = 0;
    e_rdata[0] = 0; e_rdata[1] = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_finish(input bit timed_out);
    open = 0;
    in_done = 1;
    e_done[owner] = 1'b1;
    e_err[owner]  = timed_out;
    if (!t_we) e_rdata[owner] = timed_out ? 32'hFFFF_FFFF : bus_rdata;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else if (in_done) begin
      in_done = 0;
      last = owner;
      e_done = 0;
      e_err = 0;
    end else if (open) begin
      age++;
      if (bus_ready) model_finish(1'b0);
      else if (TO != 0 && age == TO) model_finish(1'b1);
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) owner = 1 - last;
      else owner = m1_req ? 1 : 0;
      t_we    = owner ? m1_we    : m0_we;
      t_addr  = owner ? m1_addr  : m0_addr;
      t_wdata = owner ? m1_wdata : m0_wdata;
      open = 1;
      age = 0;
    end
  end

  // Compare process: every output, every cycle once the DUT has seen reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",    grant,    open ? (owner ? 2'b10 : 2'b01) : 2'b00);
      check("bus_cyc",  bus_cyc,  open);
      check("bus_we",   bus_we,   t_we);
      check("bus_addr", bus_addr, t_addr);
      check("bus_data", bus_wdata, t_wdata);
      check("m0_rdata", m0_rdata, e_rdata[0]);
      check("m1_rdata", m1_rdata, e_rdata[1]);
      check("m0_done",  m0_done,  e_done[0]);
      check("m1_done",  m1_done,  e_done[1]);
      if (e_done[0]) check("m0_err", m0_err, e_err[0]);
      if (e_done[1]) check("m1_err", m1_err, e_err[1]);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  logic [1:0] rr_g [4];
  int rr_n, d0, d1, k;
  bit prev_cyc;

  initial begin
    rst = 1; bus_ready = 0; bus_rdata = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1234; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    model_reset();

    // Reset held two cycles while m0 requests.
    step();
    chk_en = 1;
    step();
    check("rst_cyc", bus_cyc, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_done", m0_done, 1'b0);
    rst = 0;

    // Single read, ready on the 2nd ACCESS cycle.
    step();
    check("rd_grant", grant, 2'b01);
    step();
    bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
    step();
    check("rd_done", m0_done, 1'b1);
    check("rd_err", m0_err, 1'b0);
    check("rd_data", m0_rdata, 32'hDEAD_BEEF);
    check("rd_m1_data", m1_rdata, 32'h0);
    bus_ready = 0; m0_req = 0;
    step();
    check("rd_done_pulse", m0_done, 1'b0);

    // Round-robin with both requesting and a zero-wait slave, from reset.
    rst = 1;
    step();
    rst = 0; m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    bus_ready = 1; bus_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) rr_g[i] = 2'b00;
    rr_n = 0; d0 = 0; d1 = 0; prev_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_cyc && !prev_cyc && rr_n < 4) begin
        rr_g[rr_n] = grant;
        rr_n++;
      end
      prev_cyc = bus_cyc;
      if (m0_done) d0++;
      if (m1_done) d1++;
    end
    for (int i = 0; i < 4; i++) check("rr_grant", rr_g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    check("rr_m0_dones", d0, 2);
    check("rr_m1_dones", d1, 2);
    m0_req = 0; m1_req = 0;
    step(); step(); step();
    bus_ready = 0;

    // Write stability: m1 changes its inputs during ACCESS.
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h55AA;
    step();
    m1_addr = 32'hABC; m1_wdata = 32'h1111; m1_we = 0;
    for (int i = 0; i < 3; i++) begin
      check("wr_addr", bus_addr, 32'h10);
      check("wr_data", bus_wdata, 32'h55AA);
      check("wr_we", bus_we, 1'b1);
      step();
    end
    bus_ready = 1; bus_rdata = 32'h7777_7777;
    step();
    check("wr_done", m1_done, 1'b1);
    check("wr_rdata_kept", m1_rdata, 32'hCAFE_0001);
    bus_ready = 0; m1_req = 0;
    step();

    // Timeout: slave never answers.
    m0_req = 1; m0_we = 0; m0_addr = 32'h2000;
    step();
    k = 11;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (m0_done) begin k = i; break; end
    end
    check("to_latency", k, TO);
    check("to_err", m0_err, 1'b1);
    check("to_rdata", m0_rdata, 32'hFFFF_FFFF);
    m0_req = 0;
    step();

    // Ready on the last watchdog cycle wins.
    m0_req = 1;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
    step();
    check("to_edge_done", m0_done, 1'b1);
    check("to_edge_err", m0_err, 1'b0);
    check("to_edge_data", m0_rdata, 32'h0BAD_F00D);
    bus_ready = 0; m0_req = 0;
    step();

    // Abort by reset during ACCESS.
    m0_req = 1;
    step(); step();
    rst = 1;
    step();
    check("abort_cyc", bus_cyc, 1'b0);
    check("abort_grant", grant, 2'b00);
    check("abort_done", m0_done, 1'b0);
    rst = 0; m0_req = 0;
    step();
    check("abort_no_done", m0_done, 1'b0);

    // Stray ready in IDLE.
    bus_ready = 1; bus_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_done", m0_done | m1_done, 1'b0);
      check("stray_rdata", m0_rdata, 32'h0);
    end
    bus_ready = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (m0_req && m0_done && $urandom_range(0, 7) != 0) m0_req = 0;
      else if (!m0_req && $urandom_range(0, 2) == 0) m0_req = 1;
      if (m1_req && m1_done && $urandom_range(0, 7) != 0) m1_req = 0;
      else if (!m1_req && $urandom_range(0, 2) == 0) m1_req = 1;
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      bus_rdata = $urandom;
      bus_ready = bus_cyc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    end
    rst = 0; m0_req = 0; m1_req = 0; bus_ready = 1;
    step(); step(); step();
    bus_ready = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
